// File: rtl/timer_sched.sv
// Four-channel tick timer with a shared prescaler, reload registers, and pending/mask interrupt logic.
// Register bus: addr 0-3 CNT, 4-7 RLD, 8 CTRL, 9 PEND (write-1-to-clear), 10 MASK.
module timer_sched #(
    parameter int CLOCK_FREQUENCY  = 50_000_000,
    parameter int TICKS_PER_SECOND = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_en,
    input  logic [3:0]  addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        irq
);
    localparam logic [23:0] COUNT = 24'(CLOCK_FREQUENCY / TICKS_PER_SECOND - 1);

    logic [23:0] presc;
    logic        tick;
    logic        wr;
    logic [15:0] cnt [4];
    logic [15:0] rld [4];
    logic [7:0]  ctrl;
    logic [3:0]  pend;
    logic [3:0]  mask;
    logic [3:0]  pend_set;
    logic [3:0]  pend_clr;

    assign wr   = en & wr_en;
    assign tick = (presc == '0);

    always_ff @(posedge clk) begin
        if (rst || tick) presc <= COUNT;
        else             presc <= presc - 24'd1;
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic hit;
        logic dec;
        logic expire;

        // A bus write to CNTi wins over that tick's decrement and suppresses its expiry.
        assign hit         = wr && (addr == 4'(i));
        assign dec         = tick && ctrl[i] && (cnt[i] != '0);
        assign expire      = dec && (cnt[i] == 16'd1);
        assign pend_set[i] = expire && !hit;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt[i] <= '0;
                rld[i] <= '0;
            end else begin
                if (hit)
                    cnt[i] <= data_in;
                else if (expire)
                    cnt[i] <= (ctrl[4+i] && (rld[i] != '0)) ? rld[i] : '0;
                else if (dec)
                    cnt[i] <= cnt[i] - 16'd1;

                if (wr && (addr == 4'(i + 4)))
                    rld[i] <= data_in;
            end
        end
    end

    assign pend_clr = (wr && (addr == 4'd9)) ? data_in[3:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= '0;
            pend <= '0;
            mask <= '0;
        end else begin
            if (wr && (addr == 4'd8))  ctrl <= data_in[7:0];
            if (wr && (addr == 4'd10)) mask <= data_in[3:0];
            // A same-cycle expiry beats the clear.
            pend <= (pend & ~pend_clr) | pend_set;
        end
    end

    always_comb begin
        data_out = '0;
        if (addr < 4'd4)
            data_out = cnt[addr[1:0]];
        else if (addr < 4'd8)
            data_out = rld[addr[1:0]];
        else begin
            case (addr)
                4'd8:    data_out = {8'h00, ctrl};
                4'd9:    data_out = {12'h000, pend};
                4'd10:   data_out = {12'h000, mask};
                default: data_out = '0;
            endcase
        end
    end

    assign irq = |(pend & mask);

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: register vector table, directed corner sequences,
// and randomized bus traffic against a tick-counting reference model.
module tb_timer_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        irq;

    int unsigned passed = 0;
    int unsigned total  = 0;

    timer_sched #(.CLOCK_FREQUENCY(10), .TICKS_PER_SECOND(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_en    (wr_en),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq)
    );

    always #20 clk = ~clk;

    // Reference model: k counts non-reset edges since reset; every 10th edge is a tick.
    int unsigned m_cnt [4];
    int unsigned m_rld [4];
    int unsigned m_ctrl, m_pend, m_mask, k;

    function automatic int unsigned m_read(input int unsigned a);
        if (a < 4) return m_cnt[a];
        if (a < 8) return m_rld[a - 4];
        if (a == 8) return m_ctrl;
        if (a == 9) return m_pend;
        if (a == 10) return m_mask;
        return 0;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic w,
                              input int unsigned a, input int unsigned d);
        bit tick;
        int unsigned set, clr;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0;
                m_rld[i] = 0;
            end
            m_ctrl = 0; m_pend = 0; m_mask = 0; k = 0;
            return;
        end
        k++;
        tick = (k % 10 == 0);
        set = 0;
        clr = 0;
        for (int i = 0; i < 4; i++) begin
            if (e && w && a == i) m_cnt[i] = d;
            else if (tick && m_ctrl[i] && m_cnt[i] != 0) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) begin
                    set |= (1 << i);
                    if (m_ctrl[4 + i] && m_rld[i] != 0) m_cnt[i] = m_rld[i];
                end
            end
        end
        if (e && w) begin
            if (a >= 4 && a < 8) m_rld[a - 4] = d;
            if (a == 8)  m_ctrl = d & 'hFF;
            if (a == 9)  clr = d & 'hF;
            if (a == 10) m_mask = d & 'hF;
        end
        m_pend = (m_pend & ~clr) | set;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cycle(input logic r, input logic e, input logic w,
                         input logic [3:0] a, input logic [15:0] d);
        rst = r; en = e; wr_en = w; addr = a; data_in = d;
        @(posedge clk);
        model_edge(r, e, w, a, d);
        #1;
    endtask

    task automatic idle(input logic [3:0] a);
        cycle(1'b0, 1'b0, 1'b0, a, 16'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cycle(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic peek(input string name, input logic [3:0] a, input int unsigned exp);
        addr = a;
        #1;
        check(name, data_out, exp);
    endtask

    task automatic check_all(input string name);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            check(name, data_out, m_read(a));
        end
        check({name, "_irq"}, irq, ((m_pend & m_mask) != 0) ? 1 : 0);
    endtask

    // Advance until the edge just taken was a tick (at most 10 edges).
    task automatic to_tick(input logic [3:0] a);
        int unsigned n = 0;
        do begin
            idle(a);
            n++;
        end while (k % 10 != 0 && n < 10);
    endtask

    // Advance until the next edge will be a tick.
    task automatic pre_tick(input logic [3:0] a);
        while ((k + 1) % 10 != 0) idle(a);
    endtask

    typedef struct {
        logic        e;
        logic        w;
        logic [3:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 4'd0,  16'h1234, 16'h1234};
        vecs[1]  = '{1'b1, 1'b1, 4'd5,  16'hBEEF, 16'hBEEF};
        vecs[2]  = '{1'b1, 1'b1, 4'd8,  16'hABF0, 16'h00F0};
        vecs[3]  = '{1'b1, 1'b1, 4'd10, 16'hFFFF, 16'h000F};
        vecs[4]  = '{1'b0, 1'b1, 4'd0,  16'h5555, 16'h1234};
        vecs[5]  = '{1'b1, 1'b0, 4'd5,  16'h0000, 16'hBEEF};
        vecs[6]  = '{1'b1, 1'b1, 4'd12, 16'hFFFF, 16'h0000};
        vecs[7]  = '{1'b1, 1'b1, 4'd9,  16'hFFFF, 16'h0000};
        vecs[8]  = '{1'b1, 1'b1, 4'd3,  16'h0007, 16'h0007};
        vecs[9]  = '{1'b1, 1'b1, 4'd7,  16'h0000, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 4'd15, 16'h0001, 16'h0000};
        vecs[11] = '{1'b0, 1'b1, 4'd10, 16'h0000, 16'h000F};

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 4'd9, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 4'd9, 16'h0);
        check("reset_pend", data_out, 0);
        check("reset_irq", irq, 0);
        check_all("reset_regs");

        // Register vector table
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, vecs[i].e, vecs[i].w, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d", i), data_out, vecs[i].exp);
        end
        peek("rld_write_keeps_cnt", 4'd3, 16'h0007);
        check("vec_irq", irq, 0);

        // One-shot
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        wr(4'd0, 16'd3); wr(4'd10, 16'h1); wr(4'd8, 16'h0001);
        to_tick(4'd0); check("oneshot_t1", data_out, 2); check("oneshot_irq_t1", irq, 0);
        to_tick(4'd0); check("oneshot_t2", data_out, 1);
        to_tick(4'd0); check("oneshot_t3", data_out, 0); check("oneshot_irq_t3", irq, 1);
        peek("oneshot_pend", 4'd9, 16'h0001);
        for (int t = 0; t < 5; t++) begin
            to_tick(4'd0);
            check("oneshot_hold", data_out, 0);
        end
        check("oneshot_irq_hold", irq, 1);

        // Periodic
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        wr(4'd5, 16'd2); wr(4'd1, 16'd2); wr(4'd8, 16'h0022);
        to_tick(4'd1); check("per_t1", data_out, 1); peek("per_pend_t1", 4'd9, 0);
        to_tick(4'd1); check("per_t2", data_out, 2); peek("per_pend_t2", 4'd9, 2);
        wr(4'd9, 16'h0002); check("per_clear", data_out, 0);
        to_tick(4'd1); check("per_t3", data_out, 1); peek("per_pend_t3", 4'd9, 0);
        to_tick(4'd1); check("per_t4", data_out, 2); peek("per_pend_t4", 4'd9, 2);

        // Collision: CNT write on the tick, and PEND clear on expiry
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        wr(4'd0, 16'd1); wr(4'd8, 16'h0001);
        pre_tick(4'd0);
        wr(4'd0, 16'd5);
        check("coll_cnt", data_out, 5); peek("coll_pend", 4'd9, 0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        wr(4'd0, 16'd1); wr(4'd8, 16'h0001);
        pre_tick(4'd0);
        wr(4'd9, 16'h0001);
        check("coll_clr_pend", data_out, 1);

        // Mask and disable
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        wr(4'd2, 16'd1); wr(4'd8, 16'h0004);
        to_tick(4'd9); check("mask_pend", data_out, 4); check("mask_irq0", irq, 0);
        wr(4'd10, 16'h000F); check("mask_irq1", irq, 1);
        wr(4'd3, 16'd5); wr(4'd8, 16'h0008);
        to_tick(4'd3); check("dis_run", data_out, 4);
        wr(4'd8, 16'h0000);
        for (int t = 0; t < 3; t++) begin
            to_tick(4'd3);
            check("dis_hold", data_out, 4);
        end
        wr(4'd8, 16'h0008);
        to_tick(4'd3); check("dis_resume", data_out, 3);

        // Reset mid-operation, with a colliding write
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            wr(4'(i), 16'd1);
            wr(4'(i + 4), 16'd1);
        end
        wr(4'd10, 16'h000F); wr(4'd8, 16'h00FF);
        to_tick(4'd9); check("rst_pre_pend", data_out, 16'h000F); check("rst_pre_irq", irq, 1);
        cycle(1'b1, 1'b1, 1'b1, 4'd0, 16'h7777);
        check("rst_cnt0", data_out, 0); check("rst_irq", irq, 0);
        peek("rst_pend", 4'd9, 0);
        check_all("rst_all");
        wr(4'd0, 16'd2); wr(4'd8, 16'h0001);
        for (int c = 3; c <= 9; c++) idle(4'd0);
        check("rst_before_tick", data_out, 2);
        idle(4'd0);
        check("rst_first_tick", data_out, 1);

        // Randomized traffic against the model
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0);
        for (int n = 0; n < 3000; n++) begin
            logic        r, e, w;
            logic [3:0]  a;
            logic [15:0] d;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            d = 16'($urandom);
            if (a < 4'd8) d = 16'($urandom_range(0, 4));
            cycle(r, e, w, a, d);
            check("rand_read", data_out, m_read(a));
            check("rand_irq", irq, ((m_pend & m_mask) != 0) ? 1 : 0);
            if (n % 100 == 99) check_all("rand_all");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
